// File: rtl/ibex_pkg.sv
// Shared types for the interrupt sequencer: interrupt vector layout, cause encoding and FSM states.

package ibex_pkg;

    typedef struct packed {
        logic        irq_software;
        logic        irq_timer;
        logic        irq_external;
        logic [14:0] irq_fast;
    } irqs_t;

    typedef enum logic [5:0] {
        EXC_CAUSE_IRQ_SOFTWARE_M = 6'h23,
        EXC_CAUSE_IRQ_TIMER_M    = 6'h27,
        EXC_CAUSE_IRQ_EXTERNAL_M = 6'h2B,
        EXC_CAUSE_IRQ_NM         = 6'h3F
    } exc_cause_e;

    typedef enum logic [1:0] {
        IrqSeqIdle,
        IrqSeqReq,
        IrqSeqService,
        IrqSeqNmiService
    } irq_seq_state_e;

    localparam logic [4:0] IRQ_FAST_CAUSE_BASE = 5'd16;

    // Fast causes are not named enum members; they are built from the base offset.
    function automatic exc_cause_e irq_fast_cause(int unsigned idx);
        return exc_cause_e'({1'b1, IRQ_FAST_CAUSE_BASE + 5'(idx)});
    endfunction

    // True when the source behind a (non-NMI) cause is still set in the enabled vector.
    function automatic logic irq_cause_enabled(irqs_t en, exc_cause_e cause);
        logic hit;
        hit = 1'b0;
        case (cause)
            EXC_CAUSE_IRQ_SOFTWARE_M: hit = en.irq_software;
            EXC_CAUSE_IRQ_TIMER_M:    hit = en.irq_timer;
            EXC_CAUSE_IRQ_EXTERNAL_M: hit = en.irq_external;
            default: begin
                for (int unsigned i = 0; i < 15; i++) begin
                    if (cause == irq_fast_cause(i)) begin
                        hit = en.irq_fast[i];
                    end
                end
            end
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ibex_irq_prio_enc.sv
// Fixed-priority interrupt encoder: NMI, fast[0..14], external, software, timer.

module ibex_irq_prio_enc
    import ibex_pkg::*;
(
    input  irqs_t      enabled_i,
    input  logic       nmi_i,
    output logic       valid_o,
    output exc_cause_e cause_o,
    output logic       is_nmi_o
);

    always_comb begin
        valid_o  = 1'b0;
        cause_o  = EXC_CAUSE_IRQ_SOFTWARE_M;
        is_nmi_o = 1'b0;
        if (nmi_i) begin
            valid_o  = 1'b1;
            cause_o  = EXC_CAUSE_IRQ_NM;
            is_nmi_o = 1'b1;
        end else if (|enabled_i.irq_fast) begin
            valid_o = 1'b1;
            // Scan downward so the lowest set index is the last (winning) assignment.
            for (int i = 14; i >= 0; i--) begin
                if (enabled_i.irq_fast[i]) begin
                    cause_o = irq_fast_cause(i);
                end
            end
        end else if (enabled_i.irq_external) begin
            valid_o = 1'b1;
            cause_o = EXC_CAUSE_IRQ_EXTERNAL_M;
        end else if (enabled_i.irq_software) begin
            valid_o = 1'b1;
            cause_o = EXC_CAUSE_IRQ_SOFTWARE_M;
        end else if (enabled_i.irq_timer) begin
            valid_o = 1'b1;
            cause_o = EXC_CAUSE_IRQ_TIMER_M;
        end
    end

endmodule

// File: rtl/ibex_irq_sequencer.sv
// Interrupt sequencer: registers and masks raw lines, picks a winner and hands a frozen
// cause to the core through a req/ack handshake, blocking further requests until mret.

module ibex_irq_sequencer
    import ibex_pkg::*;
#(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  irqs_t               irqs_i,
    input  logic                irq_nm_i,
    input  irqs_t               mie_i,
    input  logic                mstatus_mie_i,
    input  logic                debug_mode_i,
    input  logic                irq_ack_i,
    input  logic                mret_i,
    output logic                irq_req_o,
    output exc_cause_e          irq_cause_o,
    output logic                irq_nm_o,
    output irqs_t               mip_o,
    output logic [CntWidth-1:0] taken_cnt_o
);

    irq_seq_state_e      state_q, state_d;
    irqs_t               mip_q;
    logic                nmi_q, nmi_prev_q;
    logic                nmi_pend_q, nmi_pend_d;
    exc_cause_e          cause_q, cause_d;
    logic                cause_nm_q, cause_nm_d;
    logic [CntWidth-1:0] taken_cnt_q, taken_cnt_d;

    irqs_t      enabled;
    logic       nmi_qual;
    logic       nmi_clr;
    logic       ack_take;
    logic       cand_valid;
    exc_cause_e cand_cause;
    logic       cand_nmi;

    always_comb begin
        enabled  = (mstatus_mie_i && !debug_mode_i) ? irqs_t'(mip_q & mie_i) : '0;
        nmi_qual = nmi_pend_q && !debug_mode_i;
    end

    ibex_irq_prio_enc u_prio_enc (
        .enabled_i (enabled),
        .nmi_i     (nmi_qual),
        .valid_o   (cand_valid),
        .cause_o   (cand_cause),
        .is_nmi_o  (cand_nmi)
    );

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        cause_nm_d = cause_nm_q;
        nmi_clr    = 1'b0;
        ack_take   = 1'b0;
        unique case (state_q)
            IrqSeqIdle: begin
                if (cand_valid) begin
                    state_d    = IrqSeqReq;
                    cause_d    = cand_cause;
                    cause_nm_d = cand_nmi;
                end
            end
            IrqSeqReq: begin
                if (irq_ack_i) begin
                    // Ack beats a same-cycle NMI upgrade; the NMI stays pending.
                    ack_take = 1'b1;
                    if (cause_nm_q) begin
                        state_d = IrqSeqNmiService;
                        nmi_clr = 1'b1;
                    end else begin
                        state_d = IrqSeqService;
                    end
                end else if (!cause_nm_q) begin
                    if (nmi_qual) begin
                        cause_d    = EXC_CAUSE_IRQ_NM;
                        cause_nm_d = 1'b1;
                    end else if (!irq_cause_enabled(enabled, cause_q)) begin
                        state_d = IrqSeqIdle;
                    end
                end
            end
            IrqSeqService: begin
                if (mret_i) begin
                    state_d = IrqSeqIdle;
                end else if (nmi_qual) begin
                    state_d    = IrqSeqReq;
                    cause_d    = EXC_CAUSE_IRQ_NM;
                    cause_nm_d = 1'b1;
                end
            end
            IrqSeqNmiService: begin
                if (mret_i) begin
                    state_d = IrqSeqIdle;
                end
            end
            default: state_d = IrqSeqIdle;
        endcase
    end

    always_comb begin
        nmi_pend_d  = (nmi_q && !nmi_prev_q) || (nmi_pend_q && !nmi_clr);
        taken_cnt_d = taken_cnt_q;
        if (ack_take && (taken_cnt_q != '1)) begin
            taken_cnt_d = taken_cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IrqSeqIdle;
            mip_q       <= '0;
            nmi_q       <= 1'b0;
            nmi_prev_q  <= 1'b0;
            nmi_pend_q  <= 1'b0;
            cause_q     <= EXC_CAUSE_IRQ_SOFTWARE_M;
            cause_nm_q  <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mip_q       <= irqs_i;
            nmi_q       <= irq_nm_i;
            nmi_prev_q  <= nmi_q;
            nmi_pend_q  <= nmi_pend_d;
            cause_q     <= cause_d;
            cause_nm_q  <= cause_nm_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    always_comb begin
        irq_req_o   = (state_q == IrqSeqReq);
        irq_cause_o = cause_q;
        irq_nm_o    = cause_nm_q;
        mip_o       = mip_q;
        taken_cnt_o = taken_cnt_q;
    end

endmodule

// File: doc/ibex_irq_sequencer.md
# ibex_irq_sequencer

Interrupt sequencer sitting between the external interrupt pins and the Ibex controller. It registers the raw interrupt lines, masks them with `mie`/`mstatus.MIE`/debug state, and selects one winner by fixed priority. It then presents a single request with a frozen `exc_cause_e` to the core through a req/ack handshake, and blocks further non-NMI requests until `mret`. It also exports the pending vector for `mip` and a saturating count of taken interrupts.

## Interface
Parameters:
- `CntWidth`, default 16: width of the taken-interrupt counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `irqs_i`  in  18 (`irqs_t`)  raw level interrupts: software, timer, external, fast[14:0].
- `irq_nm_i`  in  1  non-maskable interrupt line.
- `mie_i`  in  18 (`irqs_t`)  per-source enable.
- `mstatus_mie_i`  in  1  global M-mode interrupt enable.
- `debug_mode_i`  in  1  core in debug mode; blocks all requests, NMI included.
- `irq_ack_i`  in  1  core accepts the presented request.
- `mret_i`  in  1  handler return, single-cycle pulse.
- `irq_req_o`  out  1  request valid.
- `irq_cause_o`  out  6 (`exc_cause_e`)  cause of the presented request.
- `irq_nm_o`  out  1  presented request is the NMI.
- `mip_o`  out  18 (`irqs_t`)  registered pending vector.
- `taken_cnt_o`  out  `CntWidth`  number of acked requests, saturating.

## Operation
- Input stage:
  - `mip_q <= irqs_i` every cycle.
  - `nmi_q <= irq_nm_i` every cycle.
  - `nmi_pend` sets on rising edge of `nmi_q`. It clears only on an ack of an NMI request. If a new rising edge and the clearing ack occur in the same cycle, `nmi_pend` stays set.
- Candidate selection:
  - Enabled set is `mip_q & mie_i`, qualified by `mstatus_mie_i && !debug_mode_i`.
  - NMI is qualified only by `!debug_mode_i`.
- Priority, highest first:
  - NMI: cause `EXC_CAUSE_IRQ_NM`.
  - fast[0] … fast[14]: cause `{1'b1, 5'd16+i}`.
  - External (`EXC_CAUSE_IRQ_EXTERNAL_M`).
  - Software (`EXC_CAUSE_IRQ_SOFTWARE_M`).
  - Timer (`EXC_CAUSE_IRQ_TIMER_M`).
- FSM states: IDLE, REQ, SERVICE, NMI_SERVICE.
  - IDLE: any candidate → REQ. The winner's cause and NMI flag are latched into `cause_q`.
  - REQ, ack of a non-NMI request → SERVICE.
  - REQ, ack of an NMI request → NMI_SERVICE, and `nmi_pend` is cleared.
  - REQ, non-NMI request whose candidate vanishes (line dropped or mask cleared) before ack: request is withdrawn → IDLE.
  - REQ, new NMI while a non-NMI request is presented and no ack in this cycle: `cause_q` is upgraded to NMI.
  - REQ, ack and an NMI upgrade in the same cycle: the ack wins and the original cause is taken. The NMI remains pending.
  - REQ, NMI request: never withdrawn, not even if debug mode asserts.
  - SERVICE: `mret_i` → IDLE. `nmi_pend` qualified → REQ with NMI cause (NMI preempts the handler). Non-NMI candidates are ignored.
  - NMI_SERVICE: only `mret_i` → IDLE. A new NMI stays latched in `nmi_pend` and is re-requested after return.
  - `mret_i` in IDLE or REQ: ignored.
- Outputs:
  - `irq_req_o = (state == REQ)`.
  - `irq_cause_o`, `irq_nm_o` driven from `cause_q`; they are stable for as long as `irq_req_o` is high, except for the NMI upgrade.
  - `irq_ack_i` while `irq_req_o` is low: ignored.
- Counter: increments by 1 on every accepted ack and saturates at all-ones.

## Timing
- Reset values:
  - state IDLE, `irq_req_o` 0.
  - `irq_cause_o` = `EXC_CAUSE_IRQ_SOFTWARE_M`, `irq_nm_o` 0.
  - `mip_o` 0, `taken_cnt_o` 0, `nmi_pend` 0.
- Asserting reset mid-handshake drops `irq_req_o` asynchronously. Pending state is lost, including the NMI.
- Latency:
  - Line asserted at cycle N → `mip_o` at N+1 → `irq_req_o` at N+2.
  - NMI edge at N → `irq_req_o` at N+3 (extra cycle for edge detection).
- Ack at cycle N → state leaves REQ at N+1 and `irq_req_o` is low at N+1.
- Withdrawal: candidate lost at N → `irq_req_o` low at N+1.
- `mret_i` at N → IDLE at N+1. A request can be re-raised at N+2 at the earliest.

## Structure
- In `ibex_pkg`:
  - `irq_seq_state_e` (2 bits).
  - Constant `IRQ_FAST_CAUSE_BASE = 5'd16`.
  - `irqs_t` and `exc_cause_e` are reused as-is.
- Sub-module `ibex_irq_prio_enc`: combinational priority encoder. Inputs are the enabled vector and the NMI flag; outputs are `valid`, `cause` and `is_nmi`.
- FSM, registers and counter live in the top module.

## Test plan
- Timer only: `irqs_i.irq_timer=1`, `mie` timer=1, `mstatus_mie=1` at cycle 0 → `irq_req_o`=1 at cycle 2 with cause 6'h27. Ack → SERVICE, `taken_cnt_o`=1. `mret_i` → IDLE.
- Priority: fast[3], fast[9], external and timer all asserted and enabled → cause 6'h33. After `mret`, with fast[3] deasserted → cause 6'h39.
- Withdrawal: software irq presented, then `mie_i` software cleared before ack → `irq_req_o` low one cycle later, counter unchanged.
- NMI:
  - NMI pulse while `mstatus_mie=0` → request with cause 6'h3F, `irq_nm_o`=1.
  - NMI pulse during SERVICE → preempts with cause 6'h3F.
  - Second NMI during NMI_SERVICE → held until `mret`, then re-requested.
- Same-cycle ack of external (6'h2B) and NMI edge → external taken, then the NMI request follows from SERVICE. `debug_mode_i`=1 suppresses any new request.
- Saturation and reset: preload the counter near all-ones with `CntWidth`=4 and perform 20 acks → counter holds 4'hF. Assert `rst_i` during REQ → `irq_req_o` 0 immediately and all outputs at their reset values.
